// File: rtl/rr_arb4_pkg.sv
// Shared types and constants for the rr_arb4 four-channel round-robin arbiter.
package rr_arb4_pkg;

  localparam int DATA_WIDTH_DEF = 8;

  typedef logic [1:0] ch_idx_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  // Resetting last_grant to 3 makes channel 0 the first winner.
  localparam ch_idx_t LAST_GRANT_RST = 2'd3;

  function automatic logic [3:0] onehot4(input ch_idx_t idx);
    onehot4 = 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/rr_arb4_if.sv
// Handshake/data bundle between four sources, the arbiter and one sink.
interface rr_arb4_if #(parameter int DATA_WIDTH = rr_arb4_pkg::DATA_WIDTH_DEF);
  import rr_arb4_pkg::*;

  logic [DATA_WIDTH-1:0] d_in0;
  logic [DATA_WIDTH-1:0] d_in1;
  logic [DATA_WIDTH-1:0] d_in2;
  logic [DATA_WIDTH-1:0] d_in3;
  logic [3:0]            vld_in;
  logic [3:0]            rdy_in;
  ch_idx_t               sel;
  logic [DATA_WIDTH-1:0] d_out;
  logic                  vld_out;
  logic                  rdy_out;
  logic [15:0]           xfer_cnt;

  modport master (
    output d_in0, d_in1, d_in2, d_in3, vld_in, rdy_out,
    input  rdy_in, sel, d_out, vld_out, xfer_cnt
  );

  modport slave (
    input  d_in0, d_in1, d_in2, d_in3, vld_in, rdy_out,
    output rdy_in, sel, d_out, vld_out, xfer_cnt
  );

endinterface

// File: rtl/rr_pick4.sv
// Round-robin pick over four requests starting after last_grant.
// With RR_ARB4_PRIO0_EN defined, channel 0 always wins and rotation covers 1-3.
module rr_pick4
  import rr_arb4_pkg::*;
(
  input  logic [3:0] req,
  input  ch_idx_t    last_grant,
  output ch_idx_t    gnt,
  output logic       gnt_vld
);

  logic [3:0] req_rr_s;
  ch_idx_t    cand_s;
  ch_idx_t    pick_s;
  logic       hit_s;

`ifdef RR_ARB4_PRIO0_EN
  assign req_rr_s = {req[3:1], 1'b0};
`else
  assign req_rr_s = req;
`endif

  // Scan last_grant+1 .. last_grant+4 and keep the first requester.
  always_comb begin
    cand_s = last_grant;
    pick_s = last_grant;
    hit_s  = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cand_s = last_grant + ch_idx_t'(k);
      if (!hit_s && req_rr_s[cand_s]) begin
        hit_s  = 1'b1;
        pick_s = cand_s;
      end else begin
        hit_s  = hit_s;
        pick_s = pick_s;
      end
    end
  end

  // Final grant, with optional strict priority for channel 0.
  always_comb begin
    gnt     = pick_s;
    gnt_vld = hit_s;
`ifdef RR_ARB4_PRIO0_EN
    if (req[0]) begin
      gnt     = 2'd0;
      gnt_vld = 1'b1;
    end else begin
      gnt     = pick_s;
      gnt_vld = hit_s;
    end
`endif
  end

endmodule

// File: rtl/rr_arb4.sv
// Four-channel round-robin arbiter feeding a one-entry registered output slot.
// Optional macro RR_ARB4_PRIO0_EN gives channel 0 strict priority.
module rr_arb4
  import rr_arb4_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input logic      clk,
  input logic      rst_n,
  rr_arb4_if.slave bus
);

  state_t                state_r;
  state_t                state_nxt_s;
  ch_idx_t               last_grant_r;
  logic [DATA_WIDTH-1:0] d_out_r;
  logic [15:0]           xfer_cnt_r;
  ch_idx_t               gnt_s;
  logic                  gnt_vld_s;
  logic                  slot_free_s;
  logic                  accept_s;
  logic [DATA_WIDTH-1:0] d_sel_s;

  rr_pick4 u_pick (
    .req        (bus.vld_in),
    .last_grant (last_grant_r),
    .gnt        (gnt_s),
    .gnt_vld    (gnt_vld_s)
  );

  // Slot is free when empty or being drained this cycle; nothing is granted in reset.
  always_comb begin
    slot_free_s = 1'b0;
    if (rst_n && ((state_r == ST_EMPTY) || bus.rdy_out)) begin
      slot_free_s = 1'b1;
    end else begin
      slot_free_s = 1'b0;
    end
  end

  assign accept_s = slot_free_s && gnt_vld_s;

  // 4:1 data select driven by the grant index.
  always_comb begin
    d_sel_s = bus.d_in0;
    case (gnt_s)
      2'd0:    d_sel_s = bus.d_in0;
      2'd1:    d_sel_s = bus.d_in1;
      2'd2:    d_sel_s = bus.d_in2;
      2'd3:    d_sel_s = bus.d_in3;
      default: d_sel_s = bus.d_in0;
    endcase
  end

  // Next-state logic of the output slot.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_EMPTY: begin
        if (accept_s) begin
          state_nxt_s = ST_FULL;
        end else begin
          state_nxt_s = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (accept_s) begin
          state_nxt_s = ST_FULL;
        end else if (bus.rdy_out) begin
          state_nxt_s = ST_EMPTY;
        end else begin
          state_nxt_s = ST_FULL;
        end
      end
      default: state_nxt_s = ST_EMPTY;
    endcase
  end

  // Slot state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Data, grant history and transfer counter only move on an accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_out_r      <= {DATA_WIDTH{1'b0}};
      last_grant_r <= LAST_GRANT_RST;
      xfer_cnt_r   <= 16'd0;
    end else if (accept_s) begin
      d_out_r      <= d_sel_s;
      last_grant_r <= gnt_s;
      xfer_cnt_r   <= xfer_cnt_r + 16'd1;
    end else begin
      d_out_r      <= d_out_r;
      last_grant_r <= last_grant_r;
      xfer_cnt_r   <= xfer_cnt_r;
    end
  end

  assign bus.rdy_in   = accept_s ? onehot4(gnt_s) : 4'b0000;
  assign bus.sel      = accept_s ? gnt_s : last_grant_r;
  assign bus.vld_out  = (state_r == ST_FULL);
  assign bus.d_out    = d_out_r;
  assign bus.xfer_cnt = xfer_cnt_r;

endmodule

// File: tb/tb_rr_arb4.sv
// Randomized scoreboard bench for rr_arb4 with a behavioural arbitration model.
module tb_rr_arb4;

  localparam int DW = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rr_arb4_if #(.DATA_WIDTH(DW)) bus();

  rr_arb4 #(.DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] exp_q[$];
  logic [3:0]    pend;
  logic [DW-1:0] pdata[4];
  int            m_last;
  bit            m_full;
  int            m_cnt;
  int            gsel;
  int            xc;
  int            exp_seq[5];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arbitration: first requester after the previous winner, modulo 4.
  function automatic int pick(input logic [3:0] p, input int last);
`ifdef RR_ARB4_PRIO0_EN
    if (p[0]) return 0;
`endif
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = (last + k) % 4;
`ifdef RR_ARB4_PRIO0_EN
      if (c == 0) continue;
`endif
      if (p[c]) return c;
    end
    return -1;
  endfunction

  task automatic apply();
    bus.vld_in = pend;
    bus.d_in0  = pdata[0];
    bus.d_in1  = pdata[1];
    bus.d_in2  = pdata[2];
    bus.d_in3  = pdata[3];
  endtask

  // mode 0: random new requests, 1: all request with random data,
  // 2: all request with data 0x10+ch, 3: no new requests.
  task automatic cycle(input int mode, input bit rdy, output int sel_o, output int xc_o);
    int g;
    logic [3:0] exp_rdy;
    @(posedge clk);
    #1;
    xc_o = int'(bus.xfer_cnt);
    check("xfer_cnt", int'(bus.xfer_cnt), m_cnt % 65536);
    check("vld_out", int'(bus.vld_out), int'(m_full));
    for (int c = 0; c < 4; c++) begin
      if (!pend[c]) begin
        case (mode)
          0: if ($urandom_range(0, 2) == 0) begin pend[c] = 1'b1; pdata[c] = DW'($urandom); end
          1: begin pend[c] = 1'b1; pdata[c] = DW'($urandom); end
          2: begin pend[c] = 1'b1; pdata[c] = DW'(8'h10 + c); end
          default: ;
        endcase
      end
    end
    bus.rdy_out = rdy;
    apply();
    #1;
    g = (!m_full || rdy) ? pick(pend, m_last) : -1;
    exp_rdy = (g >= 0) ? (4'b0001 << g) : 4'b0000;
    check("rdy_in", int'(bus.rdy_in), int'(exp_rdy));
    check("sel", int'(bus.sel), (g >= 0) ? g : m_last);
    sel_o = int'(bus.sel);
    if (g >= 0) begin
      exp_q.push_back(pdata[g]);
      pend[g] = 1'b0;
      m_last  = g;
      m_cnt++;
      m_full  = 1'b1;
    end else if (rdy) begin
      m_full = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    pend  = 4'b0000;
    apply();
    #1;
    check("rst_vld_out", int'(bus.vld_out), 0);
    check("rst_d_out", int'(bus.d_out), 0);
    check("rst_rdy_in", int'(bus.rdy_in), 0);
    check("rst_sel", int'(bus.sel), 3);
    check("rst_xfer_cnt", int'(bus.xfer_cnt), 0);
    exp_q.delete();
    m_last = 3;
    m_full = 1'b0;
    m_cnt  = 0;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: the registered output must match the oldest accepted item; pop on drain.
  always @(negedge clk) begin
    if (rst_n && bus.vld_out) begin
      if (exp_q.size() == 0) begin
        check("d_out_unexpected", 1, 0);
      end else begin
        check("d_out", int'(bus.d_out), int'(exp_q[0]));
        if (bus.rdy_out) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog expired actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef RR_ARB4_PRIO0_EN
    exp_seq = '{0, 0, 0, 0, 0};
`else
    exp_seq = '{0, 1, 2, 3, 0};
`endif
    pend        = 4'b0000;
    for (int c = 0; c < 4; c++) pdata[c] = '0;
    bus.rdy_out = 1'b0;
    apply();
    m_last = 3;
    m_full = 1'b0;
    m_cnt  = 0;

    repeat (2) @(posedge clk);
    #1;
    check("init_vld_out", int'(bus.vld_out), 0);
    check("init_d_out", int'(bus.d_out), 0);
    check("init_sel", int'(bus.sel), 3);
    check("init_rdy_in", int'(bus.rdy_in), 0);
    check("init_xfer_cnt", int'(bus.xfer_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // All four requesting, sink always ready: grant order and data order.
    for (int i = 0; i < 5; i++) begin
      cycle(2, 1'b1, gsel, xc);
      check("rr_seq_sel", gsel, exp_seq[i]);
    end
    repeat (10) cycle(2, 1'b1, gsel, xc);
    repeat (8) cycle(3, 1'b1, gsel, xc);

    // Single request on channel 2 against a stalled sink.
    pend     = 4'b0100;
    pdata[2] = 8'hA5;
    cycle(3, 1'b0, gsel, xc);
    repeat (3) cycle(3, 1'b0, gsel, xc);
    check("stall_hold_d_out", int'(bus.d_out), 8'hA5);
    check("stall_hold_vld", int'(bus.vld_out), 1);
    repeat (3) cycle(3, 1'b1, gsel, xc);

    // Reset while holding 0x3C; channel 0 wins afterwards.
    pend     = 4'b0001;
    pdata[0] = 8'h3C;
    cycle(3, 1'b0, gsel, xc);
    cycle(3, 1'b0, gsel, xc);
    #1;
    check("pre_rst_d_out", int'(bus.d_out), 8'h3C);
    do_reset();
    cycle(2, 1'b1, gsel, xc);
    check("post_rst_sel", gsel, 0);

    // Random traffic with a randomly stalling sink.
    for (int i = 0; i < 3000; i++) begin
      cycle(0, ($urandom_range(0, 3) != 0), gsel, xc);
    end
    repeat (8) cycle(3, 1'b1, gsel, xc);

    // Counter wrap: 70000 back-to-back transfers from reset.
    do_reset();
    for (int i = 0; i < 70000; i++) cycle(1, 1'b1, gsel, xc);
    cycle(3, 1'b1, gsel, xc);
    check("xfer_wrap", xc, 4464);
    repeat (8) cycle(3, 1'b1, gsel, xc);
    check("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_arb4.md
RR_ARB4 -- requirements
Module: rr_arb4

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, the width of each data lane.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have ports d_in0..d_in3, input, DATA_WIDTH each, the channel data.
REQ-005 SHALL have port vld_in, input, 4, per-channel valid.
REQ-006 SHALL have port rdy_in, output, 4, per-channel ready, at most one bit set.
REQ-007 SHALL have port sel, output, 2, index of the current grant (drives the 4:1 select).
REQ-008 SHALL have port d_out, output, DATA_WIDTH, registered selected data.
REQ-009 SHALL have port vld_out, output, 1, d_out valid.
REQ-010 SHALL have port rdy_out, input, 1, downstream ready.
REQ-011 SHALL have port xfer_cnt, output, 16, count of accepted input transfers.

Function
REQ-012 SHALL keep a two-state FSM: EMPTY (output register invalid) and FULL (output register valid); vld_out = (state == FULL).
REQ-013 SHALL compute "slot free" = EMPTY, or FULL with rdy_out = 1.
REQ-014 SHALL grant, when slot free and any vld_in bit is set, the first requesting channel scanning last_grant+1, +2, +3, +4 (mod 4).
REQ-015 SHALL set rdy_in[g] = 1 only for the granted channel g, combinationally; rdy_in = 0 when the slot is not free or there are no requests.
REQ-016 SHALL drive sel = g while granting; otherwise sel SHALL hold last_grant.
REQ-017 SHALL, on vld_in[g] && rdy_in[g], load d_out with d_in[g], update last_grant to g, and increment xfer_cnt (mod 2^16 wrap).
REQ-018 SHALL have a latency of exactly one cycle from input accept to vld_out = 1.
REQ-019 SHALL sustain one transfer per cycle when rdy_out is held 1 (drain and refill in the same cycle).
REQ-020 SHALL go FULL->EMPTY when rdy_out = 1 and there is no new grant; EMPTY->FULL on a grant; FULL->FULL when rdy_out = 0 (d_out held stable) or on drain plus grant.
REQ-021 SHALL leave d_out, last_grant and xfer_cnt unchanged in cycles without an accept.
REQ-022 SHALL require sources to hold vld_in and data until accepted; the arbiter does not check this.

Reset
REQ-023 SHALL, on asynchronous assertion of rst_n: state = EMPTY, vld_out = 0, d_out = 0, xfer_cnt = 0, last_grant = 3 (so channel 0 wins first), sel = 3, rdy_in = 0.
REQ-024 SHALL discard any in-flight output data when reset is asserted mid-operation.
REQ-025 SHALL leave the first grant possible in the first rising clk edge after rst_n deasserts.

Configuration
REQ-026 SHALL, with macro RR_ARB4_PRIO0_EN defined, give channel 0 strict priority: vld_in[0] wins whenever the slot is free, and round-robin applies only among channels 1-3.
REQ-027 SHALL, without RR_ARB4_PRIO0_EN, apply pure round-robin over all four channels per REQ-014.

Structure
REQ-028 SHALL place the DATA_WIDTH default, typedef ch_idx_t (2-bit channel index) and the FSM state enum in package rr_arb4_pkg.
REQ-029 SHALL put the round-robin pick logic in sub-module rr_pick4 (inputs: request vector and last_grant; outputs: grant index and grant-valid).

Verification
REQ-030 SHALL cover this case: after reset, all four vld_in = 1 with data 0x10, 0x11, 0x12, 0x13 and rdy_out = 1 -> d_out sequence is 0x10, 0x11, 0x12, 0x13, 0x10 on consecutive cycles, and sel is 0, 1, 2, 3, 0.
REQ-031 SHALL cover this case: vld_in = 4'b0100, d_in2 = 0xA5, rdy_out = 0 -> one accept, vld_out = 1, d_out = 0xA5 held, rdy_in = 0 until rdy_out rises.
REQ-032 SHALL cover this case: 70000 back-to-back transfers -> xfer_cnt wraps 0xFFFF to 0x0000 and reads 70000 mod 65536 = 4464.
REQ-033 SHALL cover this case: rst_n pulsed low while FULL with d_out = 0x3C -> vld_out = 0 and d_out = 0 immediately; the next grant goes to channel 0.
REQ-034 SHALL cover this case: with RR_ARB4_PRIO0_EN, vld_in = 4'b1111 held with rdy_out = 1 -> channel 0 is granted every cycle; without the macro, the grants rotate.
